pe: RTL and testbench

Single-MAC processing element for the 2x2 systolic array that performs 3x3 convolution over a 4x4 input. Each cell multiplies its row operand `a` by its column operand `b` and adds the product into a local 8-bit accumulator. It forwards `a` to the right neighbour and `b` to the lower neighbour. Work is gated by a per-step handshake: the array controller drops `block`, waits for every cell's `c`, then raises `block` again.

---
 rtl/pe.sv | 65 ++++++
 tb/tb_pe.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/pe.sv
// Single-MAC processing element for the 2x2 systolic convolution array.
// One multiply-accumulate per low episode of block; operands forwarded right/down on MAC edges.
module pe (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       block,
    input  logic       db,
    output logic [7:0] val,
    output logic [7:0] a_out,
    output logic [7:0] b_out,
    output logic       c
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_DONE = 1'b1;

    logic [0:0] state;
    logic       mac_en;

    // db only tags the lead cell for simulation tracing; the datapath ignores it.
    logic db_unused;
    assign db_unused = db;

    // Only the low byte of the product is accumulated; the sum wraps modulo 256.
    function automatic logic [7:0] mac_wrap(input logic [7:0] acc,
                                            input logic [7:0] x,
                                            input logic [7:0] y);
        logic [15:0] prod;
        prod = 16'(x) * 16'(y);
        return acc + prod[7:0];
    endfunction

    assign mac_en = (state == S_IDLE) && !block;
    assign c      = (state == S_DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            val   <= 8'd0;
            a_out <= 8'd0;
            b_out <= 8'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (mac_en) begin
                        val   <= mac_wrap(val, a, b);
                        a_out <= a;
                        b_out <= b;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Stay here while block is low so a long low episode yields one MAC only.
                    if (block) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pe.sv
// Scoreboard bench for pe: a behavioural model pushes expected outputs per edge,
// which are popped and compared after the edge.
module tb_pe;

    logic       clk;
    logic       rst;
    logic [7:0] a;
    logic [7:0] b;
    logic       block;
    logic       db;
    logic [7:0] val;
    logic [7:0] a_out;
    logic [7:0] b_out;
    logic       c;

    pe dut (
        .clk   (clk),
        .rst   (rst),
        .a     (a),
        .b     (b),
        .block (block),
        .db    (db),
        .val   (val),
        .a_out (a_out),
        .b_out (b_out),
        .c     (c)
    );

    typedef struct packed {
        logic [7:0] v;
        logic [7:0] ao;
        logic [7:0] bo;
        logic       cc;
    } exp_t;

    exp_t sb[$];

    logic [7:0] m_val;
    logic [7:0] m_a;
    logic [7:0] m_b;
    logic       m_done;

    int errors = 0;
    int checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_val  = 8'd0;
        m_a    = 8'd0;
        m_b    = 8'd0;
        m_done = 1'b0;
    endtask

    // Drive one cycle's inputs on the falling edge, predict the rising edge, compare after it.
    task automatic tick(input string tag, input logic rv, input logic blk,
                        input logic [7:0] aa, input logic [7:0] bb);
        exp_t e;
        logic [15:0] p;
        @(negedge clk);
        rst   = rv;
        block = blk;
        a     = aa;
        b     = bb;
        if (!rv) begin
            model_reset();
        end else if (!m_done && !blk) begin
            p      = aa * bb;
            m_val  = (m_val + p[7:0]) % 256;
            m_a    = aa;
            m_b    = bb;
            m_done = 1'b1;
        end else if (m_done && blk) begin
            m_done = 1'b0;
        end
        sb.push_back('{v: m_val, ao: m_a, bo: m_b, cc: m_done});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, ".val"},   32'(val),   32'(e.v));
        chk({tag, ".a_out"}, 32'(a_out), 32'(e.ao));
        chk({tag, ".b_out"}, 32'(b_out), 32'(e.bo));
        chk({tag, ".c"},     32'(c),     32'(e.cc));
    endtask

    // Async reset pulse between edges; outputs must clear before the next edge.
    task automatic async_reset(input string tag);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        chk({tag, ".val"},   32'(val),   32'd0);
        chk({tag, ".c"},     32'(c),     32'd0);
        chk({tag, ".a_out"}, 32'(a_out), 32'd0);
        chk({tag, ".b_out"}, 32'(b_out), 32'd0);
    endtask

    task automatic run_sequence();
        // Reset held with block low and live operands.
        for (int i = 0; i < 3; i++) tick("rst_hold", 1'b0, 1'b0, 8'd5, 8'd7);
        tick("rst_rel", 1'b1, 1'b0, 8'd5, 8'd7);
        chk("rst_rel.val35", 32'(val), 32'd35);
        tick("rst_clr", 1'b1, 1'b1, 8'd5, 8'd7);

        // Single MAC per low episode.
        async_reset("rst_a");
        for (int i = 0; i < 5; i++) tick("single", 1'b1, 1'b0, 8'd3, 8'd4);
        chk("single.val12", 32'(val), 32'd12);
        tick("single_hi", 1'b1, 1'b1, 8'd3, 8'd4);
        chk("single_hi.val12", 32'(val), 32'd12);

        // Accumulation 6, 26, 27.
        async_reset("rst_b");
        tick("acc1", 1'b1, 1'b0, 8'd2, 8'd3);
        chk("acc1.val6", 32'(val), 32'd6);
        tick("acc1h", 1'b1, 1'b1, 8'd0, 8'd0);
        tick("acc2", 1'b1, 1'b0, 8'd4, 8'd5);
        chk("acc2.val26", 32'(val), 32'd26);
        tick("acc2h", 1'b1, 1'b1, 8'd0, 8'd0);
        tick("acc3", 1'b1, 1'b0, 8'd1, 8'd1);
        chk("acc3.val27", 32'(val), 32'd27);

        // Operand changes in DONE and while block is high are ignored.
        tick("samp_done", 1'b1, 1'b0, 8'd99, 8'd88);
        tick("samp_hi1", 1'b1, 1'b1, 8'd77, 8'd66);
        tick("samp_hi2", 1'b1, 1'b1, 8'd55, 8'd44);
        chk("samp.a_out", 32'(a_out), 32'd1);

        // Mid-step async reset: back in DONE with val=27 first.
        async_reset("rst_c");
        tick("acc1b", 1'b1, 1'b0, 8'd2, 8'd3);
        tick("acc1bh", 1'b1, 1'b1, 8'd0, 8'd0);
        tick("acc2b", 1'b1, 1'b0, 8'd4, 8'd5);
        tick("acc2bh", 1'b1, 1'b1, 8'd0, 8'd0);
        tick("acc3b", 1'b1, 1'b0, 8'd1, 8'd1);
        chk("mid.val27", 32'(val), 32'd27);
        async_reset("mid_rst");
        tick("fresh", 1'b1, 1'b0, 8'd6, 8'd7);
        chk("fresh.val42", 32'(val), 32'd42);
        tick("freshh", 1'b1, 1'b1, 8'd0, 8'd0);

        // Truncation of the product and wrap of the sum.
        async_reset("rst_d");
        tick("trunc", 1'b1, 1'b0, 8'd16, 8'd17);
        chk("trunc.val16", 32'(val), 32'd16);
        tick("trunch", 1'b1, 1'b1, 8'd0, 8'd0);
        tick("wrap", 1'b1, 1'b0, 8'd255, 8'd1);
        chk("wrap.val15", 32'(val), 32'd15);
        tick("wraph", 1'b1, 1'b1, 8'd0, 8'd0);

        // block toggling every cycle with random operands.
        for (int i = 0; i < 24; i++) begin
            tick("toggle", 1'b1, 1'(i % 2),
                 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        end
    endtask

    initial begin
        rst   = 1'b0;
        a     = 8'd5;
        b     = 8'd7;
        block = 1'b0;
        db    = 1'b0;
        model_reset();
        #1;
        chk("init.val", 32'(val), 32'd0);
        chk("init.c",   32'(c),   32'd0);
        run_sequence();
        db = 1'b1;
        async_reset("db_rst");
        run_sequence();
        chk("sb.empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
